// File: rtl/kpn_fifo_channel.sv
// Blocking FIFO channel between two KPN process nodes: full stalls the writer,
// empty stalls the reader; registered read port with one-cycle valid pulse.
module kpn_fifo_channel #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic wr_acc, rd_acc;

  assign full   = (count_q == DEPTH_CNT);
  assign empty  = (count_q == '0);
  assign rd_acc = rd & ~empty;
  // A read on a full channel frees the slot the concurrent write lands in.
  assign wr_acc = wr & (~full | rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    valid_d     = rd_acc;
    overflow_d  = overflow_q | (wr & ~wr_acc);
    underflow_d = underflow_q | (rd & empty);

    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
      data_out_d = mem_q[rd_ptr_q];
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out  = data_out_q;
  assign valid     = valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// Self-checking bench for kpn_fifo_channel: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_kpn_fifo_channel;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          full, empty, valid, overflow, underflow;
  logic [DW-1:0] data_out;
  logic [AW:0]   count;

  kpn_fifo_channel #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .data_in(data_in), .full(full),
    .rd(rd), .data_out(data_out), .empty(empty), .valid(valid),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  bit            m_valid, m_ovf, m_unf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("count",     32'(count),     32'(mq.size()));
    check("full",      32'(full),      32'(mq.size() == DEPTH));
    check("empty",     32'(empty),     32'(mq.size() == 0));
    check("data_out",  32'(data_out),  32'(m_dout));
    check("valid",     32'(valid),     32'(m_valid));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0; m_valid = 0; m_ovf = 0; m_unf = 0;
  endtask

  // One clock: drive at negedge, model the edge, compare #1 after it.
  task automatic step(input bit w, input bit r, input logic [DW-1:0] d);
    bit rd_ok, wr_ok;
    @(negedge clk);
    wr = w; rd = r; data_in = d;
    @(posedge clk);
    rd_ok = r && (mq.size() > 0);
    wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
    if (w && !wr_ok) m_ovf = 1;
    if (r && mq.size() == 0) m_unf = 1;
    m_valid = rd_ok;
    if (rd_ok) m_dout = mq.pop_front();
    if (wr_ok) mq.push_back(d);
    #1;
    check_model();
  endtask

  // Asynchronous reset asserted between edges, checked before any edge.
  task automatic async_reset();
    @(negedge clk);
    wr = 0; rd = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_count",    32'(count),    32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_data_out", 32'(data_out), 32'd0);
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          w;
    bit          r;
    logic [15:0] din;
    logic [3:0]  e_count;
    bit          e_empty;
    logic [15:0] e_dout;
    bit          e_valid;
    bit          e_unf;
  } vec_t;

  vec_t vt[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] exp_v;

    model_reset();
    async_reset();

    // Test 1: reset mid-stream (a read first so data_out is nonzero)
    step(1, 0, 16'h0065);
    step(1, 0, 16'h00C7);
    step(0, 1, 16'h0000);
    check("t1_pre_dout", 32'(data_out), 32'h0065);
    async_reset();
    step(0, 1, 16'h0000);
    check("t1_unf",   32'(underflow), 32'd1);
    check("t1_valid", 32'(valid),     32'd0);

    // Tests 2 and 6 as a table of hand-derived expectations
    async_reset();
    vt[0]  = '{1, 0, 16'h0065, 4'd1, 0, 16'h0000, 0, 0};
    vt[1]  = '{1, 0, 16'h0047, 4'd2, 0, 16'h0000, 0, 0};
    vt[2]  = '{1, 0, 16'h00C7, 4'd3, 0, 16'h0000, 0, 0};
    vt[3]  = '{1, 0, 16'h0053, 4'd4, 0, 16'h0000, 0, 0};
    vt[4]  = '{0, 1, 16'h0000, 4'd3, 0, 16'h0065, 1, 0};
    vt[5]  = '{0, 1, 16'h0000, 4'd2, 0, 16'h0047, 1, 0};
    vt[6]  = '{0, 1, 16'h0000, 4'd1, 0, 16'h00C7, 1, 0};
    vt[7]  = '{0, 1, 16'h0000, 4'd0, 1, 16'h0053, 1, 0};
    vt[8]  = '{0, 0, 16'h0000, 4'd0, 1, 16'h0053, 0, 0};
    vt[9]  = '{1, 1, 16'h0047, 4'd1, 0, 16'h0053, 0, 1};
    vt[10] = '{0, 1, 16'h0000, 4'd0, 1, 16'h0047, 1, 1};
    for (int i = 0; i < 11; i++) begin
      step(vt[i].w, vt[i].r, vt[i].din);
      check($sformatf("vec%0d_count", i), 32'(count),     32'(vt[i].e_count));
      check($sformatf("vec%0d_empty", i), 32'(empty),     32'(vt[i].e_empty));
      check($sformatf("vec%0d_dout", i),  32'(data_out),  32'(vt[i].e_dout));
      check($sformatf("vec%0d_valid", i), 32'(valid),     32'(vt[i].e_valid));
      check($sformatf("vec%0d_unf", i),   32'(underflow), 32'(vt[i].e_unf));
    end

    // Test 3: fill and overflow
    async_reset();
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 16'h0C80 + 16'(i));
      if (i == 7) begin
        check("t3_full",  32'(full),     32'd1);
        check("t3_count", 32'(count),    32'd8);
        check("t3_ovf0",  32'(overflow), 32'd0);
      end
    end
    check("t3_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 16'h0000);
      check("t3_rd", 32'(data_out), 32'(16'h0C80 + 16'(i)));
    end

    // Test 4: wrap-around
    async_reset();
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int i = 0; i < 5; i++) begin
        step(1, 0, 16'h0965 + 16'(rnd * 5 + i));
        check("t4_cnt_le5", 32'(count <= 5), 32'd1);
      end
      for (int i = 0; i < 5; i++) begin
        step(0, 1, 16'h0000);
        check("t4_rd", 32'(data_out), 32'(16'h0965 + 16'(rnd * 5 + i)));
      end
    end

    // Test 5: simultaneous rd & wr when full
    async_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 16'h0500 + 16'(i));
    step(1, 1, 16'h00AA);
    check("t5_dout",  32'(data_out), 32'h0500);
    check("t5_count", 32'(count),    32'd8);
    check("t5_ovf",   32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 16'h0000);
      exp_v = (i == 7) ? 16'h00AA : 16'h0501 + 16'(i);
      check("t5_rd", 32'(data_out), 32'(exp_v));
    end

    // Randomized traffic in phases biased toward filling or draining
    async_reset();
    for (int i = 0; i < 1500; i++) begin
      int unsigned pw, pr;
      pw = ((i / 100) % 2 == 0) ? 75 : 30;
      pr = ((i / 100) % 2 == 0) ? 30 : 75;
      step($urandom_range(99) < pw, $urandom_range(99) < pr, 16'($urandom));
      if (i % 400 == 399) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
